dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu_pkg.sv | 28 ++
 rtl/dmem_lsu_if.sv | 26 ++
 rtl/dmem_lsu_lane_mux.sv | 51 +++++
 rtl/dmem_lsu.sv | 125 ++++++++++++
 tb/tb_dmem_lsu.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared RV32I load/store definitions for the data-memory LSU.
// funct3 encodings, data width, the latched request bundle and a funct3 legality check.
package dmem_lsu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic                  we;
        logic [2:0]            funct3;
        logic [DATA_WIDTH-1:0] wdata;
    } lsu_req_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 > F3_SW;
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle of the LSU.
// master = execute stage, slave = dmem_lsu.
interface dmem_lsu_if;
    import dmem_lsu_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lsu_lane_mux.sv
// Byte-lane steering: load extraction/extension, store merge, alignment check.
module lsu_lane_mux
    import dmem_lsu_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            off,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] store_word,
    output logic                  misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = word[{off, 3'b000} +: 8];
    assign half_v = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_val = '0;
        case (funct3)
            F3_LB:   load_val = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
            F3_LH:   load_val = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
            F3_LW:   load_val = word;
            F3_LBU:  load_val = {{(DATA_WIDTH-8){1'b0}}, byte_v};
            F3_LHU:  load_val = {{(DATA_WIDTH-16){1'b0}}, half_v};
            default: load_val = '0;
        endcase
    end

    // Sub-word stores splice new data into the word read back from memory.
    always_comb begin
        store_word = wdata;
        case (funct3[1:0])
            2'b00: begin
                store_word = word;
                store_word[{off, 3'b000} +: 8] = wdata[7:0];
            end
            2'b01: begin
                store_word = word;
                store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

    assign misalign = ((funct3[1:0] == 2'b01) && off[0])
                   || ((funct3[1:0] == 2'b10) && (off != 2'b00));

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit on a word-wide BRAM without byte enables.
// Sub-word stores are read-modify-write; bad requests answer with rsp_err.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_lsu_if.slave             core,
    output logic [ADDR_W-1:0]     mem_r_addr,
    output logic                  mem_r_enb,
    input  logic [DATA_WIDTH-1:0] mem_r_dat,
    output logic [ADDR_W-1:0]     mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_dat,
    output logic                  mem_w_enb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    lsu_req_t              req_q;
    logic [ADDR_W+1:0]     addr_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] word_q;

    logic                  accept;
    logic                  req_err;
    logic                  req_sw;
    logic [1:0]            mux_off;
    logic [2:0]            mux_f3;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] store_word;
    logic                  misalign;
    logic                  unused_addr_hi;

    // Upper address bits are dropped: the BRAM wraps modulo its size.
    assign unused_addr_hi = ^core.req_addr[31:ADDR_W+2];

    assign accept  = core.req_valid && (state == IDLE) && !rst;
    assign mux_off = (state == IDLE) ? core.req_addr[1:0] : addr_q[1:0];
    assign mux_f3  = (state == IDLE) ? core.req_funct3 : req_q.funct3;
    assign req_err = misalign || f3_illegal(core.req_we, core.req_funct3);
    assign req_sw  = core.req_we && (core.req_funct3 == F3_SW);

    lsu_lane_mux u_lane_mux (
        .word       (word_q),
        .off        (mux_off),
        .funct3     (mux_f3),
        .wdata      (req_q.wdata),
        .load_val   (load_val),
        .store_word (store_word),
        .misalign   (misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req_q  <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
            word_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q.we     <= core.req_we;
                req_q.funct3 <= core.req_funct3;
                req_q.wdata  <= core.req_wdata;
                addr_q       <= core.req_addr[ADDR_W+1:0];
                err_q        <= req_err;
            end
            if (state == RD)
                word_q <= mem_r_dat;
        end
    end

    always_comb begin
        state_nxt      = state;
        core.req_ready = 1'b0;
        core.rsp_valid = 1'b0;
        core.rsp_rdata = '0;
        core.rsp_err   = 1'b0;
        mem_r_enb      = 1'b0;
        mem_r_addr     = '0;
        mem_w_enb      = 1'b0;
        mem_w_addr     = '0;
        mem_w_dat      = '0;
        unique case (state)
            IDLE: begin
                core.req_ready = !rst;
                if (accept) begin
                    unique case (1'b1)
                        req_err:             state_nxt = RSP;
                        !req_err && req_sw:  state_nxt = WR;
                        !req_err && !req_sw: state_nxt = RD;
                    endcase
                end
            end
            RD: begin
                mem_r_enb  = 1'b1;
                mem_r_addr = addr_q[ADDR_W+1:2];
                state_nxt  = req_q.we ? WR : RSP;
            end
            WR: begin
                mem_w_enb  = 1'b1;
                mem_w_addr = addr_q[ADDR_W+1:2];
                mem_w_dat  = store_word;
                state_nxt  = RSP;
            end
            RSP: begin
                core.rsp_valid = 1'b1;
                core.rsp_err   = err_q;
                if (!err_q && !req_q.we)
                    core.rsp_rdata = load_val;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu against a behavioural 1024-word BRAM.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  mem_r_addr;
    logic        mem_r_enb;
    logic [31:0] mem_r_dat;
    logic [9:0]  mem_w_addr;
    logic [31:0] mem_w_dat;
    logic        mem_w_enb;
    logic [31:0] mem [0:1023];
    logic [31:0] mem4_before;
    int          compared = 0;
    int          mismatched = 0;
    int          wr_count = 0;
    int          wr_before;

    always #5 clk = ~clk;

    dmem_lsu_if bus ();

    dmem_lsu #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .core       (bus),
        .mem_r_addr (mem_r_addr),
        .mem_r_enb  (mem_r_enb),
        .mem_r_dat  (mem_r_dat),
        .mem_w_addr (mem_w_addr),
        .mem_w_dat  (mem_w_dat),
        .mem_w_enb  (mem_w_enb)
    );

    assign mem_r_dat = mem[mem_r_addr];

    always @(posedge clk) begin
        if (mem_w_enb) begin
            mem[mem_w_addr] <= mem_w_dat;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        chk({tag, "/ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h0;
    endtask

    task automatic txn(input string tag, input logic we,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int rd_c,
                       input int wr_c, input int rsp_c,
                       input logic [9:0] idx, input logic [31:0] wdat,
                       input logic [31:0] rdata, input logic err);
        issue(tag, we, f3, a, wd);
        for (int c = 1; c <= rsp_c; c++) begin
            @(negedge clk);
            chk({tag, "/overlap"}, 32'(mem_r_enb & mem_w_enb), 32'd0);
            chk({tag, "/r_enb"}, 32'(mem_r_enb), 32'(c == rd_c));
            chk({tag, "/w_enb"}, 32'(mem_w_enb), 32'(c == wr_c));
            chk({tag, "/busy"}, 32'(bus.req_ready), 32'd0);
            chk({tag, "/rsp_v"}, 32'(bus.rsp_valid), 32'(c == rsp_c));
            if (c == rd_c)
                chk({tag, "/r_addr"}, 32'(mem_r_addr), 32'(idx));
            if (c == wr_c) begin
                chk({tag, "/w_addr"}, 32'(mem_w_addr), 32'(idx));
                chk({tag, "/w_dat"}, mem_w_dat, wdat);
            end
            if (c == rsp_c) begin
                chk({tag, "/rdata"}, bus.rsp_rdata, rdata);
                chk({tag, "/err"}, 32'(bus.rsp_err), 32'(err));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++)
            mem[i] = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        // Reset: everything low, including ready
        repeat (2) @(negedge clk);
        chk("rst/ready", 32'(bus.req_ready), 32'd0);
        chk("rst/rsp_v", 32'(bus.rsp_valid), 32'd0);
        chk("rst/r_enb", 32'(mem_r_enb), 32'd0);
        chk("rst/w_enb", 32'(mem_w_enb), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel/ready", 32'(bus.req_ready), 32'd1);

        // SW then LW
        txn("sw", 1, F3_SW, 32'h010, 32'hDEADBEEF, 0, 1, 2,
            10'd4, 32'hDEADBEEF, 32'h0, 0);
        txn("lw", 0, F3_LW, 32'h010, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'hDEADBEEF, 0);

        // Read-modify-write byte store
        mem[4] = 32'h11223344;
        txn("sb", 1, F3_SB, 32'h012, 32'hFFFF_FFAA, 1, 2, 3,
            10'd4, 32'h11AA3344, 32'h0, 0);
        chk("sb/mem", mem[4], 32'h11AA3344);

        // Extraction and extension
        mem[4] = 32'h80FF7F01;
        txn("lb", 0, F3_LB, 32'h013, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'hFFFFFF80, 0);
        txn("lbu", 0, F3_LBU, 32'h013, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'h00000080, 0);
        txn("lb1", 0, F3_LB, 32'h011, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'h0000007F, 0);
        txn("lh", 0, F3_LH, 32'h010, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'h00007F01, 0);
        txn("lhu", 0, F3_LHU, 32'h012, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'h000080FF, 0);
        txn("lh2", 0, F3_LH, 32'h012, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'hFFFF80FF, 0);

        // Halfword and lane-0 byte merges
        txn("sh", 1, F3_SH, 32'h012, 32'hABCD5678, 1, 2, 3,
            10'd4, 32'h56787F01, 32'h0, 0);
        txn("sb0", 1, F3_SB, 32'h010, 32'h00000022, 1, 2, 3,
            10'd4, 32'h56787F22, 32'h0, 0);

        // Rejected requests: response in cycle 1, no memory traffic
        txn("e_lw", 0, F3_LW, 32'h002, 32'h0, 0, 0, 1,
            10'd0, 32'h0, 32'h0, 1);
        txn("e_sh", 1, F3_SH, 32'h011, 32'h1234, 0, 0, 1,
            10'd0, 32'h0, 32'h0, 1);
        txn("e_lh", 0, F3_LH, 32'h011, 32'h0, 0, 0, 1,
            10'd0, 32'h0, 32'h0, 1);
        txn("e_f3l", 0, 3'b011, 32'h010, 32'h0, 0, 0, 1,
            10'd0, 32'h0, 32'h0, 1);
        txn("e_f3s", 1, 3'b100, 32'h010, 32'h55, 0, 0, 1,
            10'd0, 32'h0, 32'h0, 1);

        // Address wrap modulo 4 KiB
        txn("wrap", 0, F3_LW, 32'h1010, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'h56787F22, 0);

        // Valid held high: second load waits for the idle cycle after rsp
        mem[5] = 32'hCAFEF00D;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_LW;
        bus.req_addr   = 32'h010;
        chk("b2b/ready0", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_addr = 32'h014;
        @(negedge clk);
        chk("b2b/c1_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b/c1_raddr", 32'(mem_r_addr), 32'd4);
        @(negedge clk);
        chk("b2b/c2_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("b2b/c2_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b/c2_rdata", bus.rsp_rdata, 32'h56787F22);
        @(negedge clk);
        chk("b2b/c3_ready", 32'(bus.req_ready), 32'd1);
        chk("b2b/c3_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b/c4_renb", 32'(mem_r_enb), 32'd1);
        chk("b2b/c4_raddr", 32'(mem_r_addr), 32'd5);
        @(negedge clk);
        chk("b2b/c5_rsp", 32'(bus.rsp_valid), 32'd1);
        chk("b2b/c5_rdata", bus.rsp_rdata, 32'hCAFEF00D);

        // Reset in the RD cycle of a byte store aborts the write
        wr_before   = wr_count;
        mem4_before = mem[4];
        issue("abort", 1, F3_SB, 32'h010, 32'h99);
        @(negedge clk);
        chk("abort/rd", 32'(mem_r_enb), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort/ready", 32'(bus.req_ready), 32'd0);
        chk("abort/rsp_v", 32'(bus.rsp_valid), 32'd0);
        chk("abort/rdata", bus.rsp_rdata, 32'h0);
        chk("abort/err", 32'(bus.rsp_err), 32'd0);
        chk("abort/r_enb", 32'(mem_r_enb), 32'd0);
        chk("abort/r_addr", 32'(mem_r_addr), 32'd0);
        chk("abort/w_enb", 32'(mem_w_enb), 32'd0);
        chk("abort/w_addr", 32'(mem_w_addr), 32'd0);
        chk("abort/w_dat", mem_w_dat, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort/rel_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort/no_rsp", 32'(bus.rsp_valid), 32'd0);
            chk("abort/no_wr", 32'(mem_w_enb), 32'd0);
        end
        chk("abort/wr_count", 32'(wr_count), 32'(wr_before));
        chk("abort/mem", mem[4], mem4_before);

        txn("post", 0, F3_LW, 32'h010, 32'h0, 1, 0, 2,
            10'd4, 32'h0, 32'h56787F22, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
